mac16_stream_ctrl: RTL

- Sequencing controller that owns one 16x16 Vedic multiplier instance and drives it from a valid/ready operand stream.
- Accumulates products over a vector of beats terminated by `in_last`, then presents the dot-product result on a valid/ready output.
- Top-level controller of the 16-bit MAC unit; upstream is the operand source, downstream is the result consumer.

---
 rtl/mac16_pkg.sv | 23 ++
 rtl/Vedic_Mult16.sv | 32 +++
 rtl/mac16_stream_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mac16_pkg.sv
// ---------------------------------------------------------------------------
// mac16_pkg
// Shared definitions for the 16-bit MAC stream controller:
//   - mac_state_t : controller FSM state (IDLE/RUN/DRAIN/HOLD, 2-bit encoding)
//   - OP_W / PROD_W : operand and multiplier product widths
//   - ACC_W_DEF / CNT_W_DEF : default accumulator and beat-counter widths
// Optional build macro used by the controller: MAC16_SIGNED_EN.
// ---------------------------------------------------------------------------
package mac16_pkg;

    localparam int OP_W      = 16;
    localparam int PROD_W    = 32;
    localparam int ACC_W_DEF = 40;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } mac_state_t;

endpackage

// File: rtl/Vedic_Mult16.sv
// ---------------------------------------------------------------------------
// Vedic_Mult16
// Combinational 16x16 unsigned multiplier built from four 8x8 partial
// products combined in the vertical-and-crosswise (Urdhva) arrangement.
// Ports:
//   a [15:0] in  : multiplicand
//   b [15:0] in  : multiplier
//   c [31:0] out : unsigned product a*b
// ---------------------------------------------------------------------------
module Vedic_Mult16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] c
);

    logic [31:0] a_lo, a_hi, b_lo, b_hi;
    logic [31:0] q0, q1, q2, q3;

    always_comb begin
        a_lo = {24'd0, a[7:0]};
        a_hi = {24'd0, a[15:8]};
        b_lo = {24'd0, b[7:0]};
        b_hi = {24'd0, b[15:8]};
        q0   = a_lo * b_lo;
        q1   = a_hi * b_lo;
        q2   = a_lo * b_hi;
        q3   = a_hi * b_hi;
        // Cross terms land at weight 2^8, the high-high term at 2^16.
        c    = q0 + (q1 << 8) + (q2 << 8) + (q3 << 16);
    end

endmodule

// File: rtl/mac16_stream_ctrl.sv
// ---------------------------------------------------------------------------
// mac16_stream_ctrl
// Streams operand beats through a 3-stage multiply-accumulate pipeline
// (S1 operand register -> Vedic_Mult16 -> S2 product register -> S3
// accumulator) and presents the dot product of each vector (terminated by
// in_last) on a result port.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high; valid, once raised, holds its payload until that edge; ready may
// depend on state but never on the same-side valid.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : operand beat handshake
//   in_a, in_b [15:0]         : operands
//   in_last                   : final beat of the vector
//   out_valid/out_ready       : result handshake
//   out_acc [ACC_W-1:0]       : accumulated sum of products
//   out_count [CNT_W-1:0]     : beats in the vector (wraps)
//   out_ovf                   : accumulator overflowed during this vector
//   busy                      : FSM not in IDLE
// Build option: define MAC16_SIGNED_EN for two's-complement operands.
// ---------------------------------------------------------------------------
module mac16_stream_ctrl
    import mac16_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              busy
);

    mac_state_t state, state_nxt;

    logic               accept;
    logic               clr;
    logic               s1_valid, s1_last;
    logic [OP_W-1:0]    s1_a, s1_b;
    logic [PROD_W-1:0]  mult_p;
    logic [PROD_W-1:0]  s2_p_d;
    logic               s2_valid, s2_last;
    logic [PROD_W-1:0]  s2_p;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   p_ext;
    logic [ACC_W-1:0]   acc_sum;
    logic               step_ovf;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
`ifdef MAC16_SIGNED_EN
    logic               s1_neg;
`endif

    assign accept = in_valid & in_ready;

    Vedic_Mult16 u_mult (
        .a (s1_a),
        .b (s1_b),
        .c (mult_p)
    );

`ifdef MAC16_SIGNED_EN
    // The multiplier is unsigned: S1 holds magnitudes, the sign is restored here.
    assign s2_p_d = s1_neg ? (~mult_p + 32'd1) : mult_p;

    always_comb begin
        p_ext    = ACC_W'($signed(s2_p));
        acc_sum  = acc + p_ext;
        step_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
    end
`else
    assign s2_p_d = mult_p;

    always_comb begin
        p_ext               = ACC_W'(s2_p);
        {step_ovf, acc_sum} = {1'b0, acc} + {1'b0, p_ext};
    end
`endif

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE, RUN: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_nxt = in_last ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                // Last beat's product is being added on this edge.
                if (s2_valid && s2_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                    clr       = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
`ifdef MAC16_SIGNED_EN
            s1_neg   <= 1'b0;
`endif
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_p     <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nxt;
            s1_valid <= accept;
            if (accept) begin
                s1_last <= in_last;
`ifdef MAC16_SIGNED_EN
                s1_a    <= in_a[OP_W-1] ? (~in_a + 16'd1) : in_a;
                s1_b    <= in_b[OP_W-1] ? (~in_b + 16'd1) : in_b;
                s1_neg  <= in_a[OP_W-1] ^ in_b[OP_W-1];
`else
                s1_a    <= in_a;
                s1_b    <= in_b;
`endif
            end
            s2_valid <= s1_valid;
            s2_last  <= s1_valid & s1_last;
            s2_p     <= s2_p_d;
            if (clr) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                if (accept) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (s2_valid) begin
                    acc <= acc_sum;
                    ovf <= ovf | step_ovf;
                end
            end
        end
    end

    assign out_acc   = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;
    assign busy      = (state != IDLE);

endmodule
